// File: rtl/logic_fold.sv
`default_nettype none
// ============================================================================
//  Module   : logic_fold
//  Brief    : Streaming bitwise fold. Reduces a frame of BIT_LEN-wide operand
//             beats to one result word with a per-frame operator (AND, OR,
//             XOR, PASS, and optionally NAND/NOR/XNOR). Valid/ready on both
//             the operand and the result side.
//  Options  : LOGIC_FOLD_NEG_EN - when defined, op codes 4..6 select the
//             negated operators (fold with base operator, invert once at
//             result capture). When undefined, codes 4..6 fold as AND.
//  Revision : 1.0 - initial release
// ============================================================================
module logic_fold #(
  parameter  int BIT_LEN   = 1,
  parameter  int MAX_BEATS = 16,
  localparam int CW        = $clog2(MAX_BEATS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BIT_LEN-1:0] a,
  input  logic               last,
  input  logic [2:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BIT_LEN-1:0] c,
  output logic [CW-1:0]      beats,
  output logic               overflow
);

  localparam logic [1:0]    c_IDLE    = 2'd0;
  localparam logic [1:0]    c_ACC     = 2'd1;
  localparam logic [1:0]    c_DONE    = 2'd2;
  localparam logic [CW-1:0] c_MAX_CNT = CW'(MAX_BEATS);
  localparam logic [CW-1:0] c_ONE     = CW'(1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [BIT_LEN-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [2:0]         r_op;
  logic [BIT_LEN-1:0] r_c;
  logic [CW-1:0]      r_beats;
  logic               r_overflow;

  logic               w_beat;
  logic               w_first;
  logic               w_end;
  logic [2:0]         w_base_op;
  logic [BIT_LEN-1:0] w_fold;
  logic [BIT_LEN-1:0] w_next_acc;
  logic [CW-1:0]      w_next_cnt;
  logic               w_inv;
  logic [BIT_LEN-1:0] w_result;

  // A beat opens a new frame whenever no frame is currently being accumulated
  // (IDLE, or DONE with the held result leaving in the same cycle).
  assign w_beat     = in_valid && in_ready;
  assign w_first    = w_beat && (r_state != c_ACC);
  assign w_next_cnt = w_first ? c_ONE : (r_cnt + c_ONE);
  assign w_next_acc = w_first ? a : w_fold;
  assign w_end      = w_beat && (last || (w_next_cnt == c_MAX_CNT));

  // Map the latched operator onto its base fold operator.
  always_comb begin
    w_base_op = r_op;
`ifdef LOGIC_FOLD_NEG_EN
    if (r_op >= 3'd4 && r_op <= 3'd6) begin
      w_base_op = r_op - 3'd4;
    end
`endif
  end

  // Combine the running accumulator with the incoming beat.
  always_comb begin
    w_fold = r_acc & a;
    case (w_base_op)
      3'd1:    w_fold = r_acc | a;
      3'd2:    w_fold = r_acc ^ a;
      3'd3:    w_fold = r_acc;
      default: w_fold = r_acc & a;
    endcase
  end

`ifdef LOGIC_FOLD_NEG_EN
  logic [2:0] w_frame_op;
  // The operator of the frame being closed: live op for a single-beat frame.
  assign w_frame_op = w_first ? op : r_op;
  assign w_inv      = (w_frame_op >= 3'd4) && (w_frame_op <= 3'd6);
  assign w_result   = w_inv ? ~w_next_acc : w_next_acc;
`else
  assign w_inv    = 1'b0;
  assign w_result = w_next_acc;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_beat) begin
          w_state_nxt = last ? c_DONE : c_ACC;
        end
      end
      c_ACC: begin
        if (w_beat) begin
          w_state_nxt = w_end ? c_DONE : c_ACC;
        end
      end
      c_DONE: begin
        if (out_ready) begin
          if (w_beat) begin
            w_state_nxt = last ? c_DONE : c_ACC;
          end else begin
            w_state_nxt = c_IDLE;
          end
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Handshake outputs; in_ready is held low while reset is asserted.
  always_comb begin
    out_valid = (r_state == c_DONE);
    in_ready  = !rst && ((r_state != c_DONE) || out_ready);
  end

  // Accumulator, beat counter, latched operator and captured result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_op       <= 3'd0;
      r_c        <= '0;
      r_beats    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_beat) begin
        r_acc <= w_next_acc;
        r_cnt <= w_next_cnt;
        if (w_first) begin
          r_op <= op;
        end
      end
      if (w_end) begin
        r_c        <= w_result;
        r_beats    <= w_next_cnt;
        r_overflow <= !last && (w_next_cnt == c_MAX_CNT);
      end
    end
  end

  assign c        = r_c;
  assign beats    = r_beats;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_logic_fold.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logic_fold
//  Brief    : Scoreboard bench for logic_fold (BIT_LEN=4, MAX_BEATS=4).
//             Directed scenarios followed by randomized frames with random
//             output backpressure. Build with LOGIC_FOLD_NEG_EN defined or
//             not; the reference model follows the same macro.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_logic_fold;

  localparam int BL  = 4;
  localparam int MB  = 4;
  localparam int CWT = $clog2(MB + 1);

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [BL-1:0]  a;
  logic           last;
  logic [2:0]     op;
  logic           out_valid;
  logic           out_ready;
  logic [BL-1:0]  c;
  logic [CWT-1:0] beats;
  logic           overflow;

  typedef struct packed {
    logic [BL-1:0]  c;
    logic [CWT-1:0] b;
    logic           o;
  } res_t;

  res_t          sb[$];
  logic [BL-1:0] frame[$];
  logic [2:0]    frame_op;
  int            checks;
  int            errors;
  bit            rnd;

  logic_fold #(.BIT_LEN(BL), .MAX_BEATS(MB)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .last     (last),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .c        (c),
    .beats    (beats),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result of the buffered frame, straight from the operator rules.
  function automatic logic [BL-1:0] ref_result(input logic [2:0] o);
    int            base;
    bit            neg;
    logic [BL-1:0] r;
    base = int'(o);
    neg  = 1'b0;
`ifdef LOGIC_FOLD_NEG_EN
    if (o >= 3'd4 && o <= 3'd6) begin
      base = int'(o) - 4;
      neg  = 1'b1;
    end
`endif
    if (base > 3) base = 0;
    r = frame[0];
    for (int i = 1; i < frame.size(); i++) begin
      case (base)
        0: r = r & frame[i];
        1: r = r | frame[i];
        2: r = r ^ frame[i];
        default: r = r;
      endcase
    end
    return neg ? ~r : r;
  endfunction

  // Offer one beat; entered and left at posedge+1.
  task automatic beat(input logic [BL-1:0] av, input logic lv, input logic [2:0] ov);
    bit took;
    bit done;
    res_t e;
    in_valid = 1'b1;
    a        = av;
    last     = lv;
    op       = ov;
    done     = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      if (rnd) out_ready = ($urandom % 3) != 0;
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      if (took) begin
        done = 1'b1;
        if (frame.size() == 0) frame_op = ov;
        frame.push_back(av);
        if (lv || frame.size() == MB) begin
          e.c = ref_result(frame_op);
          e.b = CWT'(frame.size());
          e.o = !lv && (frame.size() == MB);
          sb.push_back(e);
          frame.delete();
        end
      end
    end
    if (!done) chk("beat_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_c", int'(c), 0);
    chk("rst_beats", int'(beats), 0);
    chk("rst_overflow", int'(overflow), 0);
    frame.delete();
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected results on transfer, checks hold behaviour.
  logic           pv, pr, po;
  logic [BL-1:0]  pc, lc;
  logic [CWT-1:0] pb, lb;
  logic           lo;
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      pv = 1'b0; pr = 1'b0;
      lc = '0; lb = '0; lo = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_c", int'(c), int'(pc));
        chk("hold_beats", int'(beats), int'(pb));
        chk("hold_ovf", int'(overflow), int'(po));
      end
      if (!out_valid) begin
        chk("idle_c", int'(c), int'(lc));
        chk("idle_beats", int'(beats), int'(lb));
        chk("idle_ovf", int'(overflow), int'(lo));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("res_c", int'(c), int'(e.c));
          chk("res_beats", int'(beats), int'(e.b));
          chk("res_ovf", int'(overflow), int'(e.o));
          lc = e.c; lb = e.b; lo = e.o;
        end
      end
      pv = out_valid; pr = out_ready;
      pc = c; pb = beats; po = overflow;
    end
  end

  initial begin
    checks = 0; errors = 0; rnd = 1'b0;
    rst = 1'b1; in_valid = 1'b0; a = '0; last = 1'b0; op = 3'd0; out_ready = 1'b1;
    frame_op = 3'd0;
    @(posedge clk);
    #1;
    do_reset();

    // AND frame F,E,7; op on later beats must be ignored.
    beat(4'hF, 1'b0, 3'd0);
    beat(4'hE, 1'b0, 3'd1);
    beat(4'h7, 1'b1, 3'd3);
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_valid", int'(out_valid), 1);
    @(posedge clk);
    #1;

    // XOR overflow frame, then a single-beat OR frame.
    beat(4'h1, 1'b0, 3'd2);
    beat(4'h2, 1'b0, 3'd2);
    beat(4'h4, 1'b0, 3'd2);
    beat(4'h8, 1'b0, 3'd2);
    beat(4'h3, 1'b1, 3'd1);
    in_valid = 1'b0;

    // NAND F,3 (or AND when negated ops are disabled).
    beat(4'hF, 1'b0, 3'd4);
    beat(4'h3, 1'b1, 3'd4);
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Backpressure, then transfer together with a new first beat.
    out_ready = 1'b0;
    beat(4'h1, 1'b0, 3'd1);
    beat(4'h2, 1'b1, 3'd1);
    in_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    beat(4'h5, 1'b1, 3'd0);
    in_valid = 1'b0;

    // Reset mid-frame, then PASS frame.
    beat(4'hF, 1'b0, 3'd0);
    beat(4'hE, 1'b0, 3'd0);
    in_valid = 1'b0;
    do_reset();
    beat(4'h9, 1'b0, 3'd3);
    beat(4'h1, 1'b1, 3'd3);
    in_valid = 1'b0;

    // Randomized frames with random backpressure and input gaps.
    rnd = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (($urandom % 5) == 0) begin
        in_valid  = 1'b0;
        out_ready = ($urandom % 3) != 0;
        @(posedge clk);
        #1;
      end else begin
        beat(BL'($urandom), ($urandom % 4) == 0, 3'($urandom_range(0, 7)));
      end
    end
    rnd = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 50 && sb.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
